// File: rtl/accel_dma_loader_pkg.sv
// accel_dma_loader_pkg: register map, control/status bit positions and FSM encoding shared by the DMA loader
package accel_dma_loader_pkg;

    localparam logic [7:0] REG_CTRL     = 8'd0;
    localparam logic [7:0] REG_STATUS   = 8'd1;
    localparam logic [7:0] REG_SRC      = 8'd2;
    localparam logic [7:0] REG_DST      = 8'd3;
    localparam logic [7:0] REG_LEN      = 8'd4;
    localparam logic [7:0] REG_XFER_CNT = 8'd5;

    localparam int CTRL_START = 0;
    localparam int CTRL_CLEAR = 1;
    localparam int CTRL_ABORT = 2;

    localparam int ST_BUSY    = 0;
    localparam int ST_DONE    = 1;
    localparam int ST_ERR     = 2;
    localparam int ST_TIMEOUT = 3;
    localparam int ST_ABORTED = 4;

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_RD   = 2'd1;
    localparam logic [1:0] S_WR   = 2'd2;
    localparam logic [1:0] S_DONE = 2'd3;

    typedef struct packed {
        logic aborted;
        logic timeout;
        logic err;
    } dma_flags_t;

    function automatic logic [31:0] status_word(logic busy, logic done, dma_flags_t f);
        logic [31:0] s;
        s             = '0;
        s[ST_BUSY]    = busy;
        s[ST_DONE]    = done;
        s[ST_ERR]     = f.err;
        s[ST_TIMEOUT] = f.timeout;
        s[ST_ABORTED] = f.aborted;
        return s;
    endfunction

endpackage

// File: rtl/accel_dma_loader_if.sv
// accel_dma_loader_if: Wishbone classic bus used for both the register slave port and the DMA master port
interface accel_dma_loader_if #(
    parameter int AW = 16,
    parameter int DW = 32
);
    logic          cyc;
    logic          stb;
    logic          we;
    logic [DW/8-1:0] sel;
    logic [AW-1:0] adr;
    logic [DW-1:0] dat_w;
    logic [DW-1:0] dat_r;
    logic          ack;
    logic          err;

    modport master (output cyc, stb, we, sel, adr, dat_w, input dat_r, ack, err);
    modport slave  (input cyc, stb, we, sel, adr, dat_w, output dat_r, ack, err);
endinterface

// File: rtl/dma_access_watchdog.sv
// dma_access_watchdog: per-access cycle counter that flags an access left unterminated for TIMEOUT cycles
module dma_access_watchdog #(
    parameter int TIMEOUT = 256
) (
    input  logic clk,
    input  logic rst_n,
    input  logic clr,
    input  logic en,
    output logic expired
);
    localparam int CW = $clog2(TIMEOUT);

    logic [CW-1:0] cnt;

    assign expired = en && cnt == CW'(TIMEOUT - 1);

    // Restart at every access boundary; hold at the expiry value so the flag stays up until cleared
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            cnt <= '0;
        else if (clr)
            cnt <= '0;
        else if (en && !expired)
            cnt <= cnt + 1'b1;
    end
endmodule

// File: rtl/accel_dma_loader.sv
// accel_dma_loader: Wishbone DMA that copies word blocks between system memory and the MAC accelerator banks
module accel_dma_loader
    import accel_dma_loader_pkg::*;
#(
    parameter int ADDR_WIDTH = 16,
    parameter int DATA_WIDTH = 32,
    parameter int TIMEOUT    = 256
) (
    input  logic               clk,
    input  logic               rst_n,
    accel_dma_loader_if.slave  wb,
    accel_dma_loader_if.master m
);
    logic [1:0]            state, nxt;
    logic [ADDR_WIDTH-1:0] src_reg, dst_reg, src_ptr, dst_ptr;
    logic [DATA_WIDTH-1:0] len_reg, remaining, xfer_cnt, data_q;
    dma_flags_t            flags;
    logic                  ack_q, reg_wr, ctrl_wr, do_start, do_clear, do_abort;
    logic                  in_rd, in_wr, in_done, busy, wd_fire;
    logic                  unused_sel;

    assign in_rd   = state == S_RD;
    assign in_wr   = state == S_WR;
    assign in_done = state == S_DONE;
    assign busy    = in_rd || in_wr;

    assign reg_wr   = wb.cyc && wb.stb && !ack_q && wb.we;
    assign ctrl_wr  = reg_wr && wb.adr == REG_CTRL;
    assign do_abort = ctrl_wr && wb.dat_w[CTRL_ABORT];
    assign do_clear = ctrl_wr && wb.dat_w[CTRL_CLEAR];
    assign do_start = ctrl_wr && wb.dat_w[CTRL_START] && !wb.dat_w[CTRL_ABORT];

    assign wb.ack     = ack_q;
    assign wb.err     = 1'b0;
    assign unused_sel = ^wb.sel;
    assign wb.dat_r   = wb.adr == REG_STATUS   ? DATA_WIDTH'(status_word(busy, in_done, flags)) :
                        wb.adr == REG_SRC      ? DATA_WIDTH'(src_reg) :
                        wb.adr == REG_DST      ? DATA_WIDTH'(dst_reg) :
                        wb.adr == REG_LEN      ? len_reg :
                        wb.adr == REG_XFER_CNT ? xfer_cnt : '0;

    assign m.cyc   = busy;
    assign m.stb   = busy;
    assign m.we    = in_wr;
    assign m.sel   = {(DATA_WIDTH/8){busy}};
    assign m.adr   = in_wr ? dst_ptr : in_rd ? src_ptr : '0;
    assign m.dat_w = in_wr ? data_q : '0;

    dma_access_watchdog #(.TIMEOUT(TIMEOUT)) u_wd (
        .clk     (clk),
        .rst_n   (rst_n),
        .clr     (nxt != state),
        .en      (busy),
        .expired (wd_fire)
    );

    // Slave side: one-cycle registered ack; parameter registers are frozen while a transfer runs
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ack_q   <= 1'b0;
            src_reg <= '0;
            dst_reg <= '0;
            len_reg <= '0;
        end else begin
            ack_q <= wb.cyc && wb.stb && !ack_q;
            if (reg_wr && !busy && wb.adr == REG_SRC)
                src_reg <= wb.dat_w[ADDR_WIDTH-1:0];
            if (reg_wr && !busy && wb.adr == REG_DST)
                dst_reg <= wb.dat_w[ADDR_WIDTH-1:0];
            if (reg_wr && !busy && wb.adr == REG_LEN)
                len_reg <= wb.dat_w;
        end
    end

    // Next state: abort and bus errors end a transfer early, ack advances it, the watchdog is the last resort
    always_comb begin
        nxt = state;
        if (busy)
            nxt = (do_abort || m.err || (!m.ack && wd_fire)) ? S_DONE :
                  !m.ack ? state :
                  in_rd ? S_WR :
                  remaining == DATA_WIDTH'(1) ? S_DONE : S_RD;
        else if (do_start)
            nxt = len_reg == '0 ? S_DONE : S_RD;
        else if (in_done && do_clear)
            nxt = S_IDLE;
    end

    // Transfer datapath: snapshot on start, latch read data, advance pointers and count on each write ack
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= S_IDLE;
            src_ptr   <= '0;
            dst_ptr   <= '0;
            remaining <= '0;
            xfer_cnt  <= '0;
            data_q    <= '0;
            flags     <= '0;
        end else begin
            state <= nxt;
            if (!busy && do_start) begin
                src_ptr   <= src_reg;
                dst_ptr   <= dst_reg;
                remaining <= len_reg;
                xfer_cnt  <= '0;
                flags     <= '0;
            end else if (busy && do_abort) begin
                flags.aborted <= 1'b1;
            end else if (busy && m.err) begin
                flags.err <= 1'b1;
            end else if (in_rd && m.ack) begin
                data_q <= m.dat_r;
            end else if (in_wr && m.ack) begin
                src_ptr   <= src_ptr + 1'b1;
                dst_ptr   <= dst_ptr + 1'b1;
                remaining <= remaining - 1'b1;
                xfer_cnt  <= xfer_cnt + 1'b1;
            end else if (busy && wd_fire) begin
                flags.err     <= 1'b1;
                flags.timeout <= 1'b1;
            end else if (in_done && do_clear) begin
                flags <= '0;
            end
        end
    end
endmodule

// File: tb/tb_accel_dma_loader.sv
// tb_accel_dma_loader: scoreboard bench driving the register port and modelling a registered-ack memory
module tb_accel_dma_loader;
    import accel_dma_loader_pkg::*;

    localparam int AW = 16;
    localparam int DW = 32;
    localparam int TO = 16;

    typedef struct packed {
        logic [AW-1:0] adr;
        logic [DW-1:0] dat;
    } wr_t;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int   vectors = 0;
    int   miscompares = 0;
    int   rd_cnt = 0;
    int   wr_cnt = 0;
    int   cyc_cnt = 0;
    int   err_at = -1;
    bit   hang = 1'b0;
    logic s_ack, s_err;
    wr_t  e;
    wr_t  exp_q[$];

    always #5 clk = ~clk;

    accel_dma_loader_if #(.AW(8), .DW(DW)) wb ();
    accel_dma_loader_if #(.AW(AW), .DW(DW)) m ();

    accel_dma_loader #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .TIMEOUT(TO)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .wb    (wb),
        .m     (m)
    );

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        vectors++;
        if (got !== exp) begin
            miscompares++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // Memory word at address a holds a - 0xFF, so 0x100..0x103 hold 1..4
    assign m.dat_r = 32'(m.adr) - 32'h0000_00FF;
    assign m.ack   = s_ack;
    assign m.err   = s_err;

    // Registered-ack slave: writes are checked against the scoreboard when accepted
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s_ack <= 1'b0;
            s_err <= 1'b0;
        end else begin
            s_ack <= 1'b0;
            s_err <= 1'b0;
            if (m.cyc && m.stb && !s_ack && !s_err && !hang) begin
                if (m.we) begin
                    wr_cnt <= wr_cnt + 1;
                    chk("wr_expected", 32'(exp_q.size() != 0), 32'd1);
                    if (exp_q.size() != 0) begin
                        e = exp_q.pop_front();
                        chk("wr_adr", 32'(m.adr), 32'(e.adr));
                        chk("wr_dat", m.dat_w, e.dat);
                    end
                    s_ack <= 1'b1;
                end else begin
                    rd_cnt <= rd_cnt + 1;
                    if (rd_cnt == err_at)
                        s_err <= 1'b1;
                    else
                        s_ack <= 1'b1;
                end
            end
        end
    end

    always @(negedge clk)
        if (m.cyc)
            cyc_cnt <= cyc_cnt + 1;

    task automatic wb_xfer(input logic we, input logic [7:0] a, input logic [31:0] wd, output logic [31:0] rd);
        int n = 0;
        wb.cyc   = 1'b1;
        wb.stb   = 1'b1;
        wb.we    = we;
        wb.adr   = a;
        wb.dat_w = wd;
        wb.sel   = '1;
        do begin
            @(posedge clk);
            @(negedge clk);
            n++;
        end while (!wb.ack && n < 8);
        if (!wb.ack)
            chk("wb_ack", 32'(wb.ack), 32'd1);
        rd     = wb.dat_r;
        wb.cyc = 1'b0;
        wb.stb = 1'b0;
        wb.we  = 1'b0;
    endtask

    task automatic wb_wr(input logic [7:0] a, input logic [31:0] d);
        logic [31:0] unused_rd;
        wb_xfer(1'b1, a, d, unused_rd);
    endtask

    task automatic rd_chk(input string tag, input logic [7:0] a, input logic [31:0] exp);
        logic [31:0] d;
        wb_xfer(1'b0, a, 32'd0, d);
        chk(tag, d, exp);
    endtask

    task automatic rd_mask(input string tag, input logic [7:0] a, input logic [31:0] mask, input logic [31:0] exp);
        logic [31:0] d;
        wb_xfer(1'b0, a, 32'd0, d);
        chk(tag, d & mask, exp);
    endtask

    task automatic wait_done();
        logic [31:0] d;
        int n = 0;
        do begin
            wb_xfer(1'b0, REG_STATUS, 32'd0, d);
            n++;
        end while (d[ST_BUSY] && n < 200);
        if (d[ST_BUSY])
            chk("done_wait", 32'(d[ST_BUSY]), 32'd0);
    endtask

    task automatic setup(input logic [15:0] src, input logic [15:0] dst, input logic [31:0] len, input bit push);
        wb_wr(REG_SRC, 32'(src));
        wb_wr(REG_DST, 32'(dst));
        wb_wr(REG_LEN, len);
        if (push)
            for (int i = 0; i < int'(len); i++)
                exp_q.push_back('{adr: dst + 16'(i), dat: 32'(src + 16'(i)) - 32'hFF});
    endtask

    initial begin
        int c0, w0, n;
        wb.cyc = 1'b0; wb.stb = 1'b0; wb.we = 1'b0; wb.sel = '0; wb.adr = '0; wb.dat_w = '0;
        #1;
        chk("rst_master", 32'({m.cyc, m.stb, m.we, m.sel, m.adr, m.dat_w != 0}), 32'd0);
        chk("rst_ack", 32'(wb.ack), 32'd0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        rd_chk("rst_status", REG_STATUS, 32'd0);
        rd_chk("rst_xfer", REG_XFER_CNT, 32'd0);

        setup(16'h0100, 16'h1000, 32'd4, 1'b1);
        rd_chk("rb_src", REG_SRC, 32'h0100);
        rd_chk("rb_dst", REG_DST, 32'h1000);
        rd_chk("rb_len", REG_LEN, 32'd4);
        c0 = cyc_cnt;
        wb_wr(REG_CTRL, 32'h1);
        wait_done();
        rd_chk("copy_status", REG_STATUS, 32'h2);
        rd_chk("copy_xfer", REG_XFER_CNT, 32'd4);
        chk("copy_cycles", 32'(cyc_cnt - c0), 32'd16);
        chk("copy_q_left", 32'(exp_q.size()), 32'd0);
        wb_wr(8'd7, 32'hDEAD_BEEF);
        rd_chk("unmapped_7", 8'd7, 32'd0);
        rd_chk("unmapped_ff", 8'hFF, 32'd0);
        rd_chk("ctrl_reads0", REG_CTRL, 32'd0);

        wb_wr(REG_LEN, 32'd0);
        c0 = cyc_cnt;
        wb_wr(REG_CTRL, 32'h1);
        rd_chk("len0_status", REG_STATUS, 32'h2);
        rd_chk("len0_xfer", REG_XFER_CNT, 32'd0);
        chk("len0_cycles", 32'(cyc_cnt - c0), 32'd0);

        setup(16'h0200, 16'h2000, 32'd8, 1'b1);
        err_at = rd_cnt + 2;
        c0 = cyc_cnt;
        wb_wr(REG_CTRL, 32'h1);
        wait_done();
        err_at = -1;
        rd_mask("err_status", REG_STATUS, 32'h1D, 32'h04);
        rd_chk("err_xfer", REG_XFER_CNT, 32'd2);
        chk("err_cycles", 32'(cyc_cnt - c0), 32'd10);
        chk("err_q_left", 32'(exp_q.size()), 32'd6);
        exp_q.delete();

        setup(16'h0400, 16'h4000, 32'd2, 1'b0);
        hang = 1'b1;
        c0 = cyc_cnt;
        wb_wr(REG_CTRL, 32'h1);
        wait_done();
        hang = 1'b0;
        rd_mask("to_status", REG_STATUS, 32'h1D, 32'h0C);
        rd_chk("to_xfer", REG_XFER_CNT, 32'd0);
        chk("to_cycles", 32'(cyc_cnt - c0), 32'd16);

        setup(16'h0500, 16'h5000, 32'd10, 1'b1);
        w0 = wr_cnt;
        wb_wr(REG_CTRL, 32'h1);
        wb_wr(REG_SRC, 32'h0777);
        wb_wr(REG_CTRL, 32'h1);
        n = 0;
        while (wr_cnt - w0 < 5 && n < 400) begin
            @(negedge clk);
            n++;
        end
        chk("abort_reach", 32'(wr_cnt - w0), 32'd5);
        @(negedge clk);
        wb_wr(REG_CTRL, 32'h4);
        wait_done();
        rd_mask("abort_status", REG_STATUS, 32'h1D, 32'h10);
        rd_chk("abort_xfer", REG_XFER_CNT, 32'd5);
        rd_chk("busy_src_ignored", REG_SRC, 32'h0500);
        chk("abort_q_left", 32'(exp_q.size()), 32'd5);
        exp_q.delete();
        wb_wr(REG_CTRL, 32'h2);
        rd_chk("clear_status", REG_STATUS, 32'd0);
        rd_chk("clear_xfer_kept", REG_XFER_CNT, 32'd5);

        setup(16'h0300, 16'h3000, 32'd3, 1'b0);
        wb_wr(REG_CTRL, 32'h1);
        n = 0;
        while (!m.we && n < 100) begin
            @(negedge clk);
            n++;
        end
        chk("reached_wr", 32'(m.we), 32'd1);
        rst_n = 1'b0;
        #1;
        chk("midrst_master", 32'({m.cyc, m.stb, m.we, m.sel, m.adr, m.dat_w != 0}), 32'd0);
        chk("midrst_ack", 32'(wb.ack), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        rd_chk("midrst_status", REG_STATUS, 32'd0);
        rd_chk("midrst_xfer", REG_XFER_CNT, 32'd0);
        rd_chk("midrst_len", REG_LEN, 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL global_timeout: simulation did not finish");
        $fatal(1);
    end
endmodule
